// File: rtl/spixel_draw_sequencer.sv
// spixel_draw_sequencer
//
// Command buffer and issue sequencer in front of the superpixel drawer. Game
// logic pushes (x, y, colour id) commands into a FIFO. The sequencer pops one
// command, presents it to the drawer with a single-cycle valid pulse and then
// waits for the drawer's done pulse before issuing the next. This keeps the
// drawer from being retriggered while it is still writing VGA RAM.
//
// Ports:
//   clk, rst       clock; synchronous active-high reset (shared with drawer)
//   cmd_*_i        command push side (x, y, colour id, valid)
//   cmd_rdy_o      FIFO not full; a push happens on cmd_vld_i & cmd_rdy_o
//   level_o        FIFO occupancy, 0 .. 2**FIFO_AW
//   busy_o         sequencer not idle or FIFO non-empty
//   cmd_drop_o     sticky: a command was discarded (FIFO full or off-screen)
//   timeout_err_o  sticky: drawer did not report done in time
//   dr_*_o         command to drawer; dr_vld_o is a one-cycle pulse
//   dr_done_i      drawer completion pulse
//
// Build option:
//   DRAW_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT_CYCLES cycles
//                    without dr_done_i, drops the command and sets
//                    timeout_err_o. When undefined, WAIT lasts until done and
//                    timeout_err_o is tied low.

module spixel_draw_sequencer #(
    parameter int unsigned SPIXEL_X_WIDTH = 6,
    parameter int unsigned SPIXEL_Y_WIDTH = 6,
    parameter int unsigned SPIXEL_X_MAX   = 63,
    parameter int unsigned SPIXEL_Y_MAX   = 47,
    parameter int unsigned COLOR_ID_WIDTH = 8,
    parameter int unsigned FIFO_AW        = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [SPIXEL_X_WIDTH-1:0] cmd_x_i,
    input  logic [SPIXEL_Y_WIDTH-1:0] cmd_y_i,
    input  logic [COLOR_ID_WIDTH-1:0] cmd_color_i,
    input  logic                      cmd_vld_i,
    output logic                      cmd_rdy_o,
    output logic [FIFO_AW:0]          level_o,
    output logic                      busy_o,
    output logic                      cmd_drop_o,
    output logic                      timeout_err_o,
    output logic [SPIXEL_X_WIDTH-1:0] dr_x_o,
    output logic [SPIXEL_Y_WIDTH-1:0] dr_y_o,
    output logic [COLOR_ID_WIDTH-1:0] dr_data_o,
    output logic                      dr_vld_o,
    input  logic                      dr_done_i
);

    localparam int unsigned Depth  = 1 << FIFO_AW;
    localparam int unsigned EntryW = SPIXEL_X_WIDTH + SPIXEL_Y_WIDTH + COLOR_ID_WIDTH;
    localparam logic [FIFO_AW:0] LevelFull = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    state_e state_q, state_d;

    // FIFO storage and bookkeeping
    logic [EntryW-1:0]  mem_q [Depth];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   level_q, level_d;

    logic [SPIXEL_X_WIDTH-1:0] head_x;
    logic [SPIXEL_Y_WIDTH-1:0] head_y;
    logic [COLOR_ID_WIDTH-1:0] head_c;

    logic [SPIXEL_X_WIDTH-1:0] dr_x_q;
    logic [SPIXEL_Y_WIDTH-1:0] dr_y_q;
    logic [COLOR_ID_WIDTH-1:0] dr_data_q;

    logic drop_q, terr_q, terr_set;
    logic [31:0] x_ext, y_ext;
    logic in_range, push, pop, drop_set;

    assign x_ext    = 32'(cmd_x_i);
    assign y_ext    = 32'(cmd_y_i);
    assign in_range = (x_ext <= SPIXEL_X_MAX) && (y_ext <= SPIXEL_Y_MAX);

    assign cmd_rdy_o = (level_q != LevelFull);
    assign push      = cmd_vld_i & cmd_rdy_o & in_range;
    assign drop_set  = cmd_vld_i & ~(cmd_rdy_o & in_range);
    // The head is taken only from IDLE, so a command is never popped while the
    // drawer still owns the previous one.
    assign pop       = (state_q == StIdle) && (level_q != '0);

    assign {head_x, head_y, head_c} = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
    end

`ifdef DRAW_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    // No wait counter in this build; the limit is only kept referenced so both
    // builds share one parameter list.
    if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
    end
`endif

    always_comb begin
        state_d  = state_q;
        terr_set = 1'b0;
`ifdef DRAW_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                state_d = StWait;
`ifdef DRAW_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                // Done wins over a timeout landing in the same cycle.
                if (dr_done_i) begin
                    state_d = StIdle;
`ifdef DRAW_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
                    state_d  = StIdle;
                    terr_set = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_x_i, cmd_y_i, cmd_color_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            dr_x_q    <= '0;
            dr_y_q    <= '0;
            dr_data_q <= '0;
            drop_q    <= 1'b0;
            terr_q    <= 1'b0;
`ifdef DRAW_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                dr_x_q    <= head_x;
                dr_y_q    <= head_y;
                dr_data_q <= head_c;
            end
            if (drop_set) begin
                drop_q <= 1'b1;
            end
            if (terr_set) begin
                terr_q <= 1'b1;
            end
`ifdef DRAW_TIMEOUT_EN
            cnt_q <= cnt_d;
`endif
        end
    end

    assign level_o    = level_q;
    assign busy_o     = (state_q != StIdle) || (level_q != '0);
    assign cmd_drop_o = drop_q;
    assign dr_x_o     = dr_x_q;
    assign dr_y_o     = dr_y_q;
    assign dr_data_o  = dr_data_q;
    assign dr_vld_o   = (state_q == StIssue);
`ifdef DRAW_TIMEOUT_EN
    assign timeout_err_o = terr_q;
`else
    assign timeout_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_spixel_draw_sequencer.sv
// Testbench for spixel_draw_sequencer. A transaction-level reference model
// tracks queue occupancy, the command currently owned by the drawer and the
// sticky flags; accepted commands go into a scoreboard that a separate monitor
// drains whenever the DUT pulses dr_vld_o. Honours DRAW_TIMEOUT_EN.

module tb_spixel_draw_sequencer;

    localparam int unsigned XW      = 7;  // one spare bit so x=64 is expressible
    localparam int unsigned YW      = 6;
    localparam int unsigned XMAX    = 63;
    localparam int unsigned YMAX    = 47;
    localparam int unsigned CW      = 8;
    localparam int unsigned AW      = 4;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned TIMEOUT = 20;
`ifdef DRAW_TIMEOUT_EN
    localparam bit TimeoutOn = 1'b1;
`else
    localparam bit TimeoutOn = 1'b0;
`endif

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } cmd_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [XW-1:0] cmd_x = '0;
    logic [YW-1:0] cmd_y = '0;
    logic [CW-1:0] cmd_color = '0;
    logic          cmd_vld = 1'b0;
    logic          cmd_rdy_o, busy_o, cmd_drop_o, timeout_err_o, dr_vld_o;
    logic [AW:0]   level_o;
    logic [XW-1:0] dr_x_o;
    logic [YW-1:0] dr_y_o;
    logic [CW-1:0] dr_data_o;
    logic          dr_done = 1'b0;

    spixel_draw_sequencer #(
        .SPIXEL_X_WIDTH(XW),
        .SPIXEL_Y_WIDTH(YW),
        .SPIXEL_X_MAX  (XMAX),
        .SPIXEL_Y_MAX  (YMAX),
        .COLOR_ID_WIDTH(CW),
        .FIFO_AW       (AW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_x_i      (cmd_x),
        .cmd_y_i      (cmd_y),
        .cmd_color_i  (cmd_color),
        .cmd_vld_i    (cmd_vld),
        .cmd_rdy_o    (cmd_rdy_o),
        .level_o      (level_o),
        .busy_o       (busy_o),
        .cmd_drop_o   (cmd_drop_o),
        .timeout_err_o(timeout_err_o),
        .dr_x_o       (dr_x_o),
        .dr_y_o       (dr_y_o),
        .dr_data_o    (dr_data_o),
        .dr_vld_o     (dr_vld_o),
        .dr_done_i    (dr_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    cmd_t sb[$];          // accepted, not yet seen on the drawer port
    int   mlevel  = 0;    // commands waiting in the buffer
    bit   engaged = 1'b0; // a command has been handed out and not yet finished
    int   age     = 0;    // edges since that command was handed out
    bit   mdrop   = 1'b0;
    bit   mterr   = 1'b0;
    bit   mvalid  = 1'b0;
    int   rst_cnt = 0;

    always @(posedge clk) begin
        bit acc, take;
        if (rst) begin
            mlevel  = 0;
            engaged = 1'b0;
            age     = 0;
            mdrop   = 1'b0;
            mterr   = 1'b0;
            sb.delete();
            mvalid  = 1'b1;
            rst_cnt++;
        end else begin
            acc  = cmd_vld && (mlevel < DEPTH) && (int'(cmd_x) <= XMAX) && (int'(cmd_y) <= YMAX);
            take = !engaged && (mlevel > 0);
            if (cmd_vld && !acc) mdrop = 1'b1;
            if (engaged) begin
                // age 0 is the issue cycle itself; done is only heard afterwards
                if (age >= 1 && dr_done) engaged = 1'b0;
                else if (TimeoutOn && age == TIMEOUT) begin
                    engaged = 1'b0;
                    mterr   = 1'b1;
                end else age++;
            end
            if (take) begin
                engaged = 1'b1;
                age     = 0;
            end
            mlevel = mlevel + int'(acc) - int'(take);
            if (acc) sb.push_back('{x: cmd_x, y: cmd_y, c: cmd_color});
        end
    end

    // ---------------- monitor / checker ----------------
    cmd_t last = '0;
    int   seen_rst = 0;

    always @(negedge clk) begin
        cmd_t e;
        if (mvalid) begin
            if (seen_rst != rst_cnt) begin
                last     = '0;
                seen_rst = rst_cnt;
            end
            chk("level", 32'(level_o), 32'(mlevel));
            chk("cmd_rdy", 32'(cmd_rdy_o), 32'(mlevel != DEPTH));
            chk("busy", 32'(busy_o), 32'(engaged || mlevel != 0));
            chk("dr_vld", 32'(dr_vld_o), 32'(engaged && age == 0));
            chk("cmd_drop", 32'(cmd_drop_o), 32'(mdrop));
            chk("timeout_err", 32'(timeout_err_o), 32'(mterr));
            if (dr_vld_o) begin
                if (sb.size() == 0) begin
                    chk("issue_without_cmd", 32'(dr_vld_o), 32'd0);
                end else begin
                    e    = sb.pop_front();
                    last = e;
                end
            end
            chk("dr_x", 32'(dr_x_o), 32'(last.x));
            chk("dr_y", 32'(dr_y_o), 32'(last.y));
            chk("dr_data", 32'(dr_data_o), 32'(last.c));
        end
    end

    // ---------------- drawer model ----------------
    bit resp_en   = 1'b1;
    bit resp_rand = 1'b0;
    bit noise     = 1'b0;
    int resp_delay = 102;
    int kick_req  = 0;
    int kick_ack  = 0;
    int cd        = 0;

    initial begin
        forever begin
            @(posedge clk);
            #2;
            dr_done = 1'b0;
            if (rst) cd = 0;
            else begin
                if (noise && $urandom_range(0, 19) == 0) dr_done = 1'b1;
                if (kick_req != kick_ack) begin
                    dr_done = 1'b1;
                    kick_ack++;
                end
                if (dr_vld_o && resp_en) begin
                    cd = resp_rand ? int'($urandom_range(1, 8)) : resp_delay;
                end else if (cd > 0) begin
                    cd--;
                    if (cd == 0) dr_done = 1'b1;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        cmd_vld = 1'b0;
        rst     = 1'b1;
        step(1);
        rst     = 1'b0;
    endtask

    task automatic push(input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [CW-1:0] c);
        cmd_x     = x;
        cmd_y     = y;
        cmd_color = c;
        cmd_vld   = 1'b1;
        step(1);
        cmd_vld   = 1'b0;
    endtask

    task automatic drain(input string name, input int limit);
        bit done_ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (mlevel == 0 && !engaged && sb.size() == 0) begin
                done_ok = 1'b1;
                break;
            end
            step(1);
        end
        n_chk++;
        if (!done_ok) begin
            n_fail++;
            $display("FAIL %s: not drained, level %0d pending %0d expected 0", name, mlevel,
                     sb.size());
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;

        // single command, drawer answers 102 cycles after the pulse
        resp_en = 1'b1; resp_rand = 1'b0; resp_delay = 102;
        push(7'd5, 6'd7, 8'h1C);
        @(negedge clk); chk("single_vld_early", 32'(dr_vld_o), 32'd0);
        @(negedge clk); chk("single_vld", 32'(dr_vld_o), 32'd1);
        chk("single_x", 32'(dr_x_o), 32'd5);
        chk("single_y", 32'(dr_y_o), 32'd7);
        chk("single_c", 32'(dr_data_o), 32'h1C);
        @(negedge clk); chk("single_vld_pulse", 32'(dr_vld_o), 32'd0);
        step(1);
        drain("single", 200);

        // ordering: three back-to-back pushes
        resp_rand = 1'b1;
        push(7'd1, 6'd2, 8'hA1);
        push(7'd3, 6'd4, 8'hA2);
        push(7'd5, 6'd6, 8'hA3);
        drain("order", 200);

        // full buffer with the drawer stalled
        resp_en = 1'b0;
        for (int i = 0; i < 18; i++) begin
            push(7'($urandom_range(0, XMAX)), 6'($urandom_range(0, YMAX)), 8'(i + 8'h40));
        end
        @(negedge clk);
        chk("full_level", 32'(level_o), 32'd16);
        chk("full_rdy", 32'(cmd_rdy_o), 32'd0);
        chk("full_drop", 32'(cmd_drop_o), 32'd1);
        step(1);
        resp_en = 1'b1;
        kick_req++;
        drain("full", 800);

        // range checks, each from a clean sticky flag
        do_reset();
        push(7'd64, 6'd0, 8'h11);
        @(negedge clk);
        chk("range_x_drop", 32'(cmd_drop_o), 32'd1);
        chk("range_x_level", 32'(level_o), 32'd0);
        step(1);
        do_reset();
        push(7'd0, 6'd48, 8'h22);
        @(negedge clk);
        chk("range_y_drop", 32'(cmd_drop_o), 32'd1);
        chk("range_y_level", 32'(level_o), 32'd0);
        step(1);
        do_reset();
        push(7'd63, 6'd47, 8'h33);
        drain("range_edge", 100);
        chk("range_edge_drop", 32'(cmd_drop_o), 32'd0);

        // reset while the drawer holds a command and four are queued
        resp_en = 1'b0;
        for (int i = 0; i < 5; i++) push(7'(i), 6'(i), 8'(8'h60 + i));
        @(negedge clk); chk("midrst_level_before", 32'(level_o), 32'd4);
        step(1);
        do_reset();
        @(negedge clk);
        chk("midrst_level", 32'(level_o), 32'd0);
        chk("midrst_vld", 32'(dr_vld_o), 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        chk("midrst_rdy", 32'(cmd_rdy_o), 32'd1);
        step(1);
        resp_en = 1'b1;
        push(7'd9, 6'd9, 8'h99);
        drain("post_reset", 100);

`ifdef DRAW_TIMEOUT_EN
        // done exactly on the last allowed wait cycle counts as done
        do_reset();
        resp_rand = 1'b0; resp_delay = TIMEOUT;
        push(7'd2, 6'd3, 8'h44);
        step(2 * TIMEOUT);
        chk("timeout_edge_err", 32'(timeout_err_o), 32'd0);
        // drawer silent: first command times out, second still issues
        do_reset();
        resp_en = 1'b0;
        push(7'd4, 6'd5, 8'h55);
        push(7'd6, 6'd7, 8'h66);
        step(3 * TIMEOUT + 10);
        chk("timeout_err_set", 32'(timeout_err_o), 32'd1);
        chk("timeout_next_issued", 32'(sb.size()), 32'd0);
        do_reset();
        resp_en = 1'b1;
`endif

        // randomized traffic with spurious done pulses
        do_reset();
        resp_en = 1'b1; resp_rand = 1'b1; noise = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cmd_x     = 7'($urandom_range(0, 66));
            cmd_y     = 6'($urandom_range(0, 49));
            cmd_color = 8'($urandom);
            cmd_vld   = ($urandom_range(0, 2) == 0);
            step(1);
        end
        cmd_vld = 1'b0;
        noise   = 1'b0;
        drain("random", 1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
